// File: rtl/clock_display_driver_pkg.sv
// Shared constants for the clock display driver: segment codes, digit
// slot indices, conversion FSM states and segment-encoding helpers.
package clock_disp_pkg;

  // Active-high segment patterns, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Digit slot positions, left to right on the board.
  localparam logic [2:0] IDX_HOUR_T = 3'd0;
  localparam logic [2:0] IDX_HOUR_O = 3'd1;
  localparam logic [2:0] IDX_MIN_T  = 3'd2;
  localparam logic [2:0] IDX_MIN_O  = 3'd3;
  localparam logic [2:0] IDX_SEC_T  = 3'd4;
  localparam logic [2:0] IDX_SEC_O  = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONV_H = 3'd1,
    CONV_M = 3'd2,
    CONV_S = 3'd3,
    COMMIT = 3'd4
  } state_e;

  // One BCD digit to its segment pattern; a non-decimal nibble shows a dash.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = SEG_0;
      4'd1:    r = SEG_1;
      4'd2:    r = SEG_2;
      4'd3:    r = SEG_3;
      4'd4:    r = SEG_4;
      4'd5:    r = SEG_5;
      4'd6:    r = SEG_6;
      4'd7:    r = SEG_7;
      4'd8:    r = SEG_8;
      4'd9:    r = SEG_9;
      default: r = SEG_DASH;
    endcase
    return r;
  endfunction

  // Three-digit BCD to {tens, ones} patterns; anything >= 100 shows two dashes.
  function automatic logic [13:0] seg_pair(input logic [11:0] bcd);
    return (bcd[11:8] != 4'd0) ? {SEG_DASH, SEG_DASH}
                               : {seg_digit(bcd[7:4]), seg_digit(bcd[3:0])};
  endfunction

endpackage

// File: rtl/clock_display_driver_if.sv
// Bundle between the clock core (time values in) and the display pins
// (scan outputs). The driver takes the slave side.
interface clock_display_driver_if;
  logic [7:0] hour;
  logic [7:0] minute;
  logic [7:0] second;
  logic       ring;
  logic [5:0] dig_en;
  logic [6:0] seg;
  logic       dp;

  modport master (output hour, minute, second, ring, input dig_en, seg, dp);
  modport slave  (input hour, minute, second, ring, output dig_en, seg, dp);
endinterface

// File: rtl/clock_display_driver_bcd_conv8.sv
// bcd_conv8: sequential double-dabble, 8-bit binary to 12-bit BCD.
// The first shift happens on the start edge, so the one-cycle done pulse
// (with the result) lands exactly 8 cycles after start.
module bcd_conv8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  // {hundreds, tens, ones, remaining binary bits}
  logic [19:0] sr_r;
  logic [2:0]  cnt_r;
  logic        busy_r;
  logic        done_r;

  // One iteration: add 3 to every BCD column >= 5, then shift left by one.
  function automatic logic [19:0] dabble_step(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    t[11:8]  = (t[11:8]  >= 4'd5) ? t[11:8]  + 4'd3 : t[11:8];
    t[15:12] = (t[15:12] >= 4'd5) ? t[15:12] + 4'd3 : t[15:12];
    t[19:16] = (t[19:16] >= 4'd5) ? t[19:16] + 4'd3 : t[19:16];
    return {t[18:0], 1'b0};
  endfunction

  // Load-and-shift on start, then seven more shifts; flag done after the eighth.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_r   <= 20'd0;
      cnt_r  <= 3'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      sr_r   <= dabble_step({12'd0, bin});
      cnt_r  <= 3'd1;
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      sr_r <= dabble_step(sr_r);
      if (cnt_r == 3'd7) begin
        cnt_r  <= 3'd0;
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        cnt_r  <= cnt_r + 3'd1;
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done = done_r;
  assign bcd  = sr_r[19:8];

endmodule

// File: rtl/clock_display_driver.sv
// clock_display_driver: six-digit multiplexed seven-segment scanner.
// Time values are snapshotted once per frame, converted to BCD one after
// another and committed to the display registers together, so a frame
// never mixes old and new digits.
// Optional feature macro: DISP_BLINK_EN (blank segments on a slow phase
// while the alarm rings).
module clock_display_driver
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  clock_display_driver_if.slave  bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       idx_r;
  logic             first_r;
  logic             tick_s, frame_tick_s, frame_start_s;
  state_e           state_r, state_s;
  logic             start_s, latch_s, commit_s, issued_r;
  logic [7:0]       snap_h_r, snap_m_r, snap_s_r, conv_in_s;
  logic             conv_done_s;
  logic [11:0]      conv_bcd_s, bcd_h_r, bcd_m_r, bcd_s_r;
  logic [13:0]      pair_h_s, pair_m_s, pair_s_s;
  logic [5:0][6:0]  codes_s, disp_r;
  logic             blank_s;
  logic [5:0]       dig_en_r;
  logic [6:0]       seg_r, seg_s;
  logic             dp_r, dp_s;

  // Select one slot's pattern; slots 6 and 7 do not exist and read blank.
  function automatic logic [6:0] pick(input logic [5:0][6:0] arr, input logic [2:0] i);
    logic [6:0] r;
    case (i)
      IDX_HOUR_T: r = arr[0];
      IDX_HOUR_O: r = arr[1];
      IDX_MIN_T:  r = arr[2];
      IDX_MIN_O:  r = arr[3];
      IDX_SEC_T:  r = arr[4];
      IDX_SEC_O:  r = arr[5];
      default:    r = SEG_BLANK;
    endcase
    return r;
  endfunction

  assign tick_s        = (cnt_r == CNT_W'(SCAN_DIV - 1));
  assign frame_tick_s  = tick_s && (idx_r == IDX_SEC_O);
  assign frame_start_s = frame_tick_s || first_r;

  // Slot prescaler and digit index; first_r marks the first cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= '0;
      idx_r   <= IDX_HOUR_T;
      first_r <= 1'b1;
    end else begin
      first_r <= 1'b0;
      if (tick_s) begin
        cnt_r <= '0;
        idx_r <= (idx_r == IDX_SEC_O) ? IDX_HOUR_T : idx_r + 3'd1;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Conversion FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Conversion FSM next state: one start per CONV state, advance on done.
  always_comb begin
    state_s   = state_r;
    start_s   = 1'b0;
    latch_s   = 1'b0;
    commit_s  = 1'b0;
    conv_in_s = snap_h_r;
    case (state_r)
      IDLE: begin
        if (frame_start_s) begin
          latch_s = 1'b1;
          state_s = CONV_H;
        end else begin
          state_s = IDLE;
        end
      end
      CONV_H: begin
        conv_in_s = snap_h_r;
        start_s   = !issued_r;
        state_s   = conv_done_s ? CONV_M : CONV_H;
      end
      CONV_M: begin
        conv_in_s = snap_m_r;
        start_s   = !issued_r;
        state_s   = conv_done_s ? CONV_S : CONV_M;
      end
      CONV_S: begin
        conv_in_s = snap_s_r;
        start_s   = !issued_r;
        state_s   = conv_done_s ? COMMIT : CONV_S;
      end
      COMMIT: begin
        commit_s = 1'b1;
        state_s  = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Remember that the current CONV state has already fired its start pulse.
  always_ff @(posedge clk) begin
    if (rst)              issued_r <= 1'b0;
    else if (conv_done_s) issued_r <= 1'b0;
    else if (start_s)     issued_r <= 1'b1;
    else                  issued_r <= issued_r;
  end

  // Frame snapshot of the time inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_h_r <= 8'd0;
      snap_m_r <= 8'd0;
      snap_s_r <= 8'd0;
    end else if (latch_s) begin
      snap_h_r <= bus.hour;
      snap_m_r <= bus.minute;
      snap_s_r <= bus.second;
    end else begin
      snap_h_r <= snap_h_r;
      snap_m_r <= snap_m_r;
      snap_s_r <= snap_s_r;
    end
  end

  bcd_conv8 u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start_s),
    .bin   (conv_in_s),
    .done  (conv_done_s),
    .bcd   (conv_bcd_s)
  );

  // Park each converter result according to which value was being converted.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_h_r <= 12'd0;
      bcd_m_r <= 12'd0;
      bcd_s_r <= 12'd0;
    end else if (conv_done_s) begin
      case (state_r)
        CONV_H:  bcd_h_r <= conv_bcd_s;
        CONV_M:  bcd_m_r <= conv_bcd_s;
        CONV_S:  bcd_s_r <= conv_bcd_s;
        default: bcd_h_r <= bcd_h_r;
      endcase
    end else begin
      bcd_h_r <= bcd_h_r;
    end
  end

  // Segment codes for all six digits from the parked BCD results.
  always_comb begin
    pair_h_s = seg_pair(bcd_h_r);
    pair_m_s = seg_pair(bcd_m_r);
    pair_s_s = seg_pair(bcd_s_r);
    codes_s     = '0;
    codes_s[0]  = pair_h_s[13:7];
    codes_s[1]  = pair_h_s[6:0];
    codes_s[2]  = pair_m_s[13:7];
    codes_s[3]  = pair_m_s[6:0];
    codes_s[4]  = pair_s_s[13:7];
    codes_s[5]  = pair_s_s[6:0];
  end

  // Display registers: all six digits change together in COMMIT.
  always_ff @(posedge clk) begin
    if (rst)           disp_r <= '0;
    else if (commit_s) disp_r <= codes_s;
    else               disp_r <= disp_r;
  end

`ifdef DISP_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BF_W-1:0] bcnt_r;
  logic            phase_r;

  // Blink phase toggles every BLINK_FRAMES frames while ringing; ring low clears it.
  always_ff @(posedge clk) begin
    if (rst || !bus.ring) begin
      bcnt_r  <= '0;
      phase_r <= 1'b0;
    end else if (frame_tick_s) begin
      if (bcnt_r == BF_W'(BLINK_FRAMES - 1)) begin
        bcnt_r  <= '0;
        phase_r <= ~phase_r;
      end else begin
        bcnt_r <= bcnt_r + BF_W'(1);
      end
    end else begin
      bcnt_r <= bcnt_r;
    end
  end

  // Gating with ring lets blanking stop on the very next output cycle.
  assign blank_s = phase_r & bus.ring;
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_ring_s;
  assign unused_ring_s = bus.ring;
  assign blank_s       = 1'b0;
`endif

  // Output selection; during COMMIT the fresh code bypasses the display register.
  always_comb begin
    if (blank_s) begin
      seg_s = SEG_BLANK;
      dp_s  = 1'b0;
    end else if (commit_s) begin
      seg_s = pick(codes_s, idx_r);
      dp_s  = (idx_r == IDX_HOUR_O) || (idx_r == IDX_MIN_O);
    end else begin
      seg_s = pick(disp_r, idx_r);
      dp_s  = (idx_r == IDX_HOUR_O) || (idx_r == IDX_MIN_O);
    end
  end

  // Registered pin drive, one cycle behind the index.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_en_r <= 6'd0;
      seg_r    <= SEG_BLANK;
      dp_r     <= 1'b0;
    end else begin
      dig_en_r <= 6'd1 << idx_r;
      seg_r    <= seg_s;
      dp_r     <= dp_s;
    end
  end

  assign bus.dig_en = dig_en_r;
  assign bus.seg    = seg_r;
  assign bus.dp     = dp_r;

endmodule

// File: tb/tb_clock_display_driver.sv
// Scoreboard bench for clock_display_driver with SCAN_DIV=32, BLINK_FRAMES=2.
// The driver queues expected pin states tagged with the cycle (relative to
// the latest reset release) at which they must appear; a negedge monitor
// pops and compares them as the run reaches each cycle.
module tb_clock_display_driver;

  typedef struct {
    int         cyc;
    logic [5:0] de;
    logic [6:0] sg;
    logic       dp;
    string      nm;
  } exp_t;

`ifdef DISP_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   gcyc = 0;
  int   base = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  clock_display_driver_if bus();

  clock_display_driver #(.SCAN_DIV(32), .BLINK_FRAMES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) gcyc <= gcyc + 1;

  // Queue an expectation at cycle n after the latest release.
  task automatic push(input int n, input logic [5:0] de, input logic [6:0] sg,
                      input logic dp, input string nm);
    exp_t e;
    e.cyc = base + n;
    e.de  = de;
    e.sg  = sg;
    e.dp  = dp;
    e.nm  = nm;
    exp_q.push_back(e);
  endtask

  // Expectation for a scan slot: enable is one-hot, separators at slots 1 and 3.
  task automatic push_slot(input int n, input int slot, input logic [6:0] sg,
                           input string nm);
    logic dpx;
    dpx = (sg != 7'h00) && (slot == 1 || slot == 3);
    push(n, 6'd1 << slot, sg, dpx, nm);
  endtask

  task automatic go_to(input int n);
    while (gcyc < base + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every queued expectation whose cycle has arrived.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= gcyc) begin
      e = exp_q.pop_front();
      checks = checks + 1;
      if (e.cyc < gcyc) begin
        failures = failures + 1;
        $display("FAIL %s missed_cycle got_cycle=%0d required_cycle=%0d", e.nm, gcyc, e.cyc);
      end else if (bus.dig_en !== e.de || bus.seg !== e.sg || bus.dp !== e.dp) begin
        failures = failures + 1;
        $display("FAIL %s cyc=%0d got dig_en=%b seg=%h dp=%b required dig_en=%b seg=%h dp=%b",
                 e.nm, gcyc - base, bus.dig_en, bus.seg, bus.dp, e.de, e.sg, e.dp);
      end
    end
  end

  initial begin
    bus.hour   = 8'd12;
    bus.minute = 8'd34;
    bus.second = 8'd56;
    bus.ring   = 1'b0;
    @(posedge clk);
    #1;
    // Reset held: everything dark.
    for (int k = 2; k <= 5; k++) push(k, 6'd0, 7'h00, 1'b0, "reset_hold");
    while (gcyc < 6) begin
      @(posedge clk);
      #1;
    end
    rst  = 1'b0;
    base = gcyc;

    // First frame after release: blank until commit at 28, digits from 29.
    push_slot(1,  0, 7'h00, "rel_digen");
    push_slot(16, 0, 7'h00, "pre_commit");
    push_slot(28, 0, 7'h00, "commit_cycle");
    push_slot(29, 0, 7'h06, "h_tens_12");
    push_slot(48, 1, 7'h5B, "h_ones_12");
    push_slot(80, 2, 7'h4F, "m_tens_34");
    push_slot(112, 3, 7'h66, "m_ones_34");
    push_slot(144, 4, 7'h6D, "s_tens_56");
    push_slot(176, 5, 7'h7D, "s_ones_56");

    // Mid-frame change of second: held until the next latch at 383.
    go_to(250);
    bus.second = 8'd7;
    push_slot(336, 4, 7'h6D, "sec_hold_t");
    push_slot(368, 5, 7'h7D, "sec_hold_o");
    push_slot(528, 4, 7'h3F, "sec7_tens");
    push_slot(560, 5, 7'h07, "sec7_ones");

    // Zero and out-of-range: latched at 767, commit 795, visible 796.
    go_to(600);
    bus.hour   = 8'd0;
    bus.minute = 8'd150;
    push_slot(795, 0, 7'h06, "before_commit");
    push_slot(796, 0, 7'h3F, "h0_tens_exact");
    push_slot(816, 1, 7'h3F, "h0_ones");
    push_slot(848, 2, 7'h40, "m150_tens_dash");
    push_slot(880, 3, 7'h40, "m150_ones_dash");
    push_slot(912, 4, 7'h3F, "s7_tens");
    push_slot(944, 5, 7'h07, "s7_ones");
    push(972, 6'd0, 7'h00, 1'b0, "midconv_rst");
    push(973, 6'd0, 7'h00, 1'b0, "midconv_rst");

    // Reset at L+12 of the frame latched at 959.
    go_to(971);
    rst = 1'b1;
    go_to(974);
    rst      = 1'b0;
    bus.ring = 1'b1;
    base     = gcyc;

    push_slot(1,  0, 7'h00, "after_abort_digen");
    push_slot(15, 0, 7'h00, "after_abort_blank");
    push_slot(28, 0, 7'h00, "after_abort_28");
    push_slot(29, 0, 7'h3F, "after_abort_29");
    push_slot(48, 1, 7'h3F, "after_abort_h_o");

    // Ring held: phase toggles at frame ticks 383 and 767, 1151.
    push_slot(300,  3, 7'h40,                    "blink_normal_a");
    push_slot(400,  0, BLINK ? 7'h00 : 7'h3F,    "blink_blank_a");
    push_slot(700,  3, BLINK ? 7'h00 : 7'h40,    "blink_blank_b");
    push_slot(800,  0, 7'h3F,                    "blink_normal_b");
    push_slot(1200, 1, BLINK ? 7'h00 : 7'h3F,    "blink_blank_c");
    push_slot(1201, 1, 7'h3F,                    "ring_drop");
    go_to(1200);
    bus.ring = 1'b0;

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      failures = failures + 1;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
